// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam int NPORTS    = 2;
  localparam int PORT_CORE = 0;
  localparam int PORT_LOAD = 1;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: one-hot winner from requests and the preferred-port pointer.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              ptr,
  output logic [NPORTS-1:0] win,
  output logic              valid
);
  always_comb begin
    win = req;
    // Contention resolves toward the pointer; a lone requester always wins.
    if (&req) win = ptr ? 2'b10 : 2'b01;
  end
  assign valid = |req;
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing the single data-RAM port between core and loader.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int n  = 32,
  parameter int AW = 6
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] we,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic [n-1:0]      wdata0,
  input  logic [n-1:0]      wdata1,
  output logic [NPORTS-1:0] gnt,
  output logic [NPORTS-1:0] rvalid,
  output logic [n-1:0]      rdata,
  output logic              ramR,
  output logic              ramW,
  output logic [AW-1:0]     ramAddr,
  output logic [n-1:0]      ramDataW,
  input  logic [n-1:0]      ramDataR
);
  state_t            state, nxt;
  logic              ptr;
  logic [NPORTS-1:0] win, own;
  logic              win_vld;
  logic              go, capture, win_we;

  rr_pick2 u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (win),
    .valid (win_vld)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nxt;
  end

  // ramW doubles as the latched direction of the transaction in ISSUE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (win_vld) nxt = ISSUE;
      ISSUE:   nxt = ramW ? IDLE : WAIT;
      WAIT:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    go      = (state == IDLE) && win_vld;
    capture = (state == WAIT);
    win_we  = |(we & win);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      ramR     <= 1'b0;
      ramW     <= 1'b0;
      ramAddr  <= '0;
      ramDataW <= '0;
      own      <= '0;
      ptr      <= 1'b0;
    end else begin
      gnt    <= go ? win : '0;
      ramW   <= go && win_we;
      ramR   <= go && !win_we;
      rvalid <= capture ? own : '0;
      if (capture) rdata <= ramDataR;
      if (go) begin
        ramAddr  <= win[PORT_LOAD] ? addr1  : addr0;
        ramDataW <= win[PORT_LOAD] ? wdata1 : wdata0;
        own      <= win;
        // Prefer the loser next time.
        ptr      <= win[PORT_CORE];
      end
    end
  end
endmodule
